// File: rtl/contador_modos.sv
// Multi-mode synchronous counter: up, down, down-by-3 or parallel load, with a
// registered wrap flag (rco) for cascading and a load acknowledge pulse.
module contador_modos #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enable,
  input  logic             ent,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             load_done
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    LOADED
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             rco_q, rco_d;
  logic             load_done_q;
  logic             act;
  logic [WIDTH:0]   upSum, downDiff, down3Diff;

  assign act = enable & ent;

  // The extra top bit of each result is the carry/borrow, taken from the pre-update count.
  assign upSum     = {1'b0, q_q} + (WIDTH+1)'(1);
  assign downDiff  = {1'b0, q_q} - (WIDTH+1)'(1);
  assign down3Diff = {1'b0, q_q} - (WIDTH+1)'(3);

  always_comb begin
    q_d     = q_q;
    rco_d   = 1'b0;
    state_d = IDLE;
    if (act) begin
      state_d = COUNT;
      unique case (modo)
        2'b00: begin
          q_d   = upSum[WIDTH-1:0];
          rco_d = upSum[WIDTH];
        end
        2'b01: begin
          q_d   = downDiff[WIDTH-1:0];
          rco_d = downDiff[WIDTH];
        end
        2'b10: begin
          q_d   = down3Diff[WIDTH-1:0];
          rco_d = down3Diff[WIDTH];
        end
        default: begin
          q_d     = D;
          state_d = LOADED;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      q_q         <= '0;
      rco_q       <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      rco_q       <= rco_d;
      load_done_q <= (state_d == LOADED);
    end
  end

  assign Q         = q_q;
  assign rco       = rco_q;
  assign load_done = load_done_q;

endmodule

// File: tb/tb_contador_modos.sv
// Two chained counters (stage1.ent = stage0.rco) checked every cycle against an
// arithmetic reference model, plus directed sequences with literal expectations.
module tb_contador_modos;

  localparam int WIDTH = 4;
  localparam int MAXV  = 1 << WIDTH;

  logic             clk;
  logic             reset_L;
  logic             enable;
  logic             ent0;
  logic [1:0]       modo;
  logic [WIDTH-1:0] D0, D1;
  logic [WIDTH-1:0] Q0, Q1;
  logic             rco0, rco1, ld0, ld1;

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  int mq0, mq1;
  bit mr0, mr1, ml0, ml1;
  int nq0, nq1;
  bit nr0, nr1, nl0, nl1;

  contador_modos #(.WIDTH(WIDTH)) stage0 (
    .clk(clk), .reset_L(reset_L), .enable(enable), .ent(ent0),
    .modo(modo), .D(D0), .Q(Q0), .rco(rco0), .load_done(ld0)
  );

  contador_modos #(.WIDTH(WIDTH)) stage1 (
    .clk(clk), .reset_L(reset_L), .enable(enable), .ent(rco0),
    .modo(modo), .D(D1), .Q(Q1), .rco(rco1), .load_done(ld1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference for one stage: plain modular arithmetic on the old count.
  task automatic modelStage(input int q, input bit act, input int m, input int d,
                            output int nq, output bit nr, output bit nl);
    nq = q;
    nr = 1'b0;
    nl = 1'b0;
    if (act) begin
      case (m)
        0: begin nq = (q + 1) % MAXV;        nr = (q == MAXV - 1); end
        1: begin nq = (q + MAXV - 1) % MAXV; nr = (q == 0);        end
        2: begin nq = (q + MAXV - 3) % MAXV; nr = (q < 3);         end
        default: begin nq = d; nl = 1'b1; end
      endcase
    end
  endtask

  always @(posedge clk) begin
    if (!reset_L) begin
      mq0 = 0; mr0 = 0; ml0 = 0;
      mq1 = 0; mr1 = 0; ml1 = 0;
    end else begin
      modelStage(mq0, enable && ent0, int'(modo), int'(D0), nq0, nr0, nl0);
      modelStage(mq1, enable && mr0,  int'(modo), int'(D1), nq1, nr1, nl1);
      mq0 = nq0; mr0 = nr0; ml0 = nl0;
      mq1 = nq1; mr1 = nr1; ml1 = nl1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison of both stages against the model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("model Q0", int'(Q0), mq0);
      checkOutput("model rco0", int'(rco0), int'(mr0));
      checkOutput("model ld0", int'(ld0), int'(ml0));
      checkOutput("model Q1", int'(Q1), mq1);
      checkOutput("model rco1", int'(rco1), int'(mr1));
      checkOutput("model ld1", int'(ld1), int'(ml1));
    end
  end

  task automatic applyStimulus(input bit rst, input bit en, input bit et,
                               input logic [1:0] m, input int d0, input int d1);
    reset_L = rst;
    enable  = en;
    ent0    = et;
    modo    = m;
    D0      = WIDTH'(d0);
    D1      = WIDTH'(d1);
    @(negedge clk);
  endtask

  task automatic resetBoth();
    applyStimulus(0, 1, 1, 2'b00, 0, 0);
  endtask

  initial begin
    reset_L = 0; enable = 0; ent0 = 1; modo = 0; D0 = 0; D1 = 0;
    @(negedge clk);

    // Reset held with enable active, then count 1, 2, 3.
    applyStimulus(0, 1, 1, 2'b00, 9, 9);
    checking = 1;
    checkOutput("reset Q", int'(Q0), 0);
    applyStimulus(0, 1, 1, 2'b00, 9, 9);
    checkOutput("reset Q 2nd", int'(Q0), 0);
    checkOutput("reset rco", int'(rco0), 0);
    checkOutput("reset ld", int'(ld0), 0);
    applyStimulus(1, 1, 1, 2'b00, 9, 9);
    checkOutput("count 1", int'(Q0), 1);
    applyStimulus(1, 1, 1, 2'b00, 9, 9);
    checkOutput("count 2", int'(Q0), 2);
    applyStimulus(1, 1, 1, 2'b00, 9, 9);
    checkOutput("count 3", int'(Q0), 3);

    // Up wrap from a load of 14.
    applyStimulus(1, 1, 1, 2'b11, 14, 0);
    checkOutput("load 14", int'(Q0), 14);
    checkOutput("load_done pulse", int'(ld0), 1);
    applyStimulus(1, 1, 1, 2'b00, 0, 0);
    checkOutput("up 15", int'(Q0), 15);
    checkOutput("load_done clear", int'(ld0), 0);
    checkOutput("no rco at 15", int'(rco0), 0);
    applyStimulus(1, 1, 1, 2'b00, 0, 0);
    checkOutput("up wrap 0", int'(Q0), 0);
    checkOutput("up wrap rco", int'(rco0), 1);
    applyStimulus(1, 1, 1, 2'b00, 0, 0);
    checkOutput("up 1", int'(Q0), 1);
    checkOutput("rco one cycle", int'(rco0), 0);

    // Down-by-3 underflow, then switch to down.
    applyStimulus(1, 1, 1, 2'b11, 4, 0);
    checkOutput("load 4", int'(Q0), 4);
    applyStimulus(1, 1, 1, 2'b10, 0, 0);
    checkOutput("dn3 1", int'(Q0), 1);
    applyStimulus(1, 1, 1, 2'b10, 0, 0);
    checkOutput("dn3 wrap 14", int'(Q0), 14);
    checkOutput("dn3 rco", int'(rco0), 1);
    applyStimulus(1, 1, 1, 2'b10, 0, 0);
    checkOutput("dn3 11", int'(Q0), 11);
    checkOutput("dn3 rco clear", int'(rco0), 0);
    applyStimulus(1, 1, 1, 2'b01, 0, 0);
    checkOutput("dn 10", int'(Q0), 10);
    applyStimulus(1, 1, 1, 2'b01, 0, 0);
    checkOutput("dn 9", int'(Q0), 9);

    // Hold at 7 while modo and D wander.
    applyStimulus(1, 1, 1, 2'b11, 7, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 2'(i), 3 + i, 5);
      checkOutput("hold Q", int'(Q0), 7);
      checkOutput("hold rco", int'(rco0), 0);
      checkOutput("hold ld", int'(ld0), 0);
    end
    applyStimulus(1, 1, 0, 2'b00, 0, 0);
    checkOutput("hold ent low", int'(Q0), 7);

    // Cascade: 0:15 up, upper stage increments one edge after the wrap.
    resetBoth();
    applyStimulus(1, 1, 1, 2'b11, 15, 6);
    checkOutput("casc Q0 15", int'(Q0), 15);
    checkOutput("casc Q1 0", int'(Q1), 0);
    applyStimulus(1, 1, 1, 2'b00, 0, 0);
    checkOutput("casc Q0 wrap", int'(Q0), 0);
    checkOutput("casc rco0", int'(rco0), 1);
    checkOutput("casc Q1 still 0", int'(Q1), 0);
    applyStimulus(1, 1, 1, 2'b00, 0, 0);
    checkOutput("casc Q1 1", int'(Q1), 1);
    checkOutput("casc Q0 1", int'(Q0), 1);

    // Reset during rco and during a load.
    applyStimulus(1, 1, 1, 2'b11, 15, 0);
    applyStimulus(1, 1, 1, 2'b00, 0, 0);
    checkOutput("pre-reset rco", int'(rco0), 1);
    applyStimulus(0, 1, 1, 2'b11, 5, 5);
    checkOutput("mid reset Q", int'(Q0), 0);
    checkOutput("mid reset rco", int'(rco0), 0);
    checkOutput("mid reset ld", int'(ld0), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 49) != 0),
                    ($urandom_range(0, 5) != 0),
                    ($urandom_range(0, 7) != 0),
                    2'($urandom_range(0, 3)),
                    int'($urandom_range(0, MAXV - 1)),
                    int'($urandom_range(0, MAXV - 1)));
    end

    checking = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
